// File: rtl/adder32_bist_pkg.sv
// Shared types and constants for the 32-bit adder BIST controller.
// Corner-vector tables are only consumed when ADDER32_BIST_CORNER_EN is defined.
package adder32_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  localparam int NUM_CORNERS = 4;
  localparam logic [0:3][31:0] CORNER_A   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA};
  localparam logic [0:3][31:0] CORNER_B   = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555};
  localparam logic [0:3]       CORNER_CIN = 4'b1101;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/adder32_bist_lfsr.sv
// 32-bit Galois LFSR with step enable; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module adder32_bist_lfsr
  import adder32_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/adder32_bist_ctrl.sv
// BIST driver/checker for the registered 32-bit adder: issues LFSR operands,
// tracks expected {cout,s} through a LAT-deep delay line and scores results.
// Optional: ADDER32_BIST_CORNER_EN prepends four fixed corner vectors per run.
module adder32_bist_ctrl
  import adder32_bist_pkg::*;
#(
  parameter int          LAT    = 2,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED_A = 32'h1234_5678,
  parameter logic [31:0] SEED_B = 32'h8765_4321
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  output logic [0:31]      dut_a,
  output logic [0:31]      dut_b,
  output logic             dut_cin,
  input  logic [0:31]      dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("adder32_bist_ctrl: LAT out of range");
  end

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] idx;
    logic [32:0]      exp;
  } entry_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] num_q, issue_idx;
  logic [2:0]       drain_cnt;
  logic [31:0]      a_q, b_q;
  logic             cin_q;
  logic [31:0]      lfsr_a, lfsr_b;
  logic             accept, issue, drain_exit, lfsr_step;
  logic [31:0]      vec_a, vec_b;
  logic             vec_cin, corner_sel;
  logic [32:0]      vec_exp;
  entry_t           line [LAT];
  entry_t           tail;
  logic             cmp_fail;
  logic [CNT_W-1:0] err_next;

  adder32_bist_lfsr #(.SEED(SEED_A)) u_lfsr_a (
    .clk  (CLK),
    .rst_n(RESET_N),
    .step (lfsr_step),
    .value(lfsr_a)
  );

  adder32_bist_lfsr #(.SEED(SEED_B)) u_lfsr_b (
    .clk  (CLK),
    .rst_n(RESET_N),
    .step (lfsr_step),
    .value(lfsr_b)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    drain_exit = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (issue_idx == num_q - CNT_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 3'(LAT - 1)) begin
          drain_exit = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef ADDER32_BIST_CORNER_EN
    corner_sel = (issue_idx < CNT_W'(NUM_CORNERS));
    vec_a      = corner_sel ? CORNER_A[issue_idx[1:0]]   : lfsr_a;
    vec_b      = corner_sel ? CORNER_B[issue_idx[1:0]]   : lfsr_b;
    vec_cin    = corner_sel ? CORNER_CIN[issue_idx[1:0]] : issue_idx[0];
`else
    corner_sel = 1'b0;
    vec_a      = lfsr_a;
    vec_b      = lfsr_b;
    vec_cin    = issue_idx[0];
`endif
    vec_exp    = {1'b0, vec_a} + {1'b0, vec_b} + {32'h0, vec_cin};
    lfsr_step  = issue && !corner_sel;
  end

  // The tail entry lines up with the adder output sampled at this edge.
  assign tail     = line[LAT-1];
  assign cmp_fail = tail.valid && ({dut_cout, dut_s} != tail.exp);
  assign err_next = (cmp_fail && err_count != ALL_ONES) ? err_count + CNT_W'(1) : err_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      num_q         <= '0;
      issue_idx     <= '0;
      drain_cnt     <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= ALL_ONES;
      // NOTE: the delay line is only LAT entries, so whole entries are reset;
      // strictly only the valid bits need it.
      for (int i = 0; i < LAT; i++) line[i] <= '0;
    end else begin
      if (accept) begin
        num_q     <= num_vectors;
        issue_idx <= '0;
      end else if (issue) begin
        issue_idx <= issue_idx + CNT_W'(1);
      end

      if (issue) begin
        a_q   <= vec_a;
        b_q   <= vec_b;
        cin_q <= vec_cin;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      line[0] <= '{valid: issue, idx: issue_idx, exp: vec_exp};
      for (int i = 1; i < LAT; i++) line[i] <= line[i-1];

      if (accept) begin
        err_count     <= '0;
        first_err_idx <= ALL_ONES;
      end else begin
        err_count <= err_next;
        if (cmp_fail && first_err_idx == ALL_ONES) first_err_idx <= tail.idx;
      end

      // err_next already includes a compare landing on the exit edge.
      if (accept)          pass <= (num_vectors == '0);
      else if (drain_exit) pass <= (err_next == '0);
    end
  end

  assign dut_a   = a_q;
  assign dut_b   = b_q;
  assign dut_cin = cin_q;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

endmodule
